// File: rtl/udp_loopback_buf_if.sv
// udp_loopback_buf_if: receive byte stream, transmit replay handshake and statistics of udp_loopback_buf
// master: the UDP rx/tx user logic side; slave: the buffer.
interface udp_loopback_buf_if;
  logic        rec_en;
  logic [7:0]  rec_data;
  logic        rec_pkt_done;
  logic [15:0] rec_byte_num;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic        tx_req;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;
  modport master (
    output rec_en, rec_data, rec_pkt_done, rec_byte_num, tx_req, tx_done,
    input  tx_start_en, tx_byte_num, tx_data, pkt_cnt, drop_cnt
  );
  modport slave (
    input  rec_en, rec_data, rec_pkt_done, rec_byte_num, tx_req, tx_done,
    output tx_start_en, tx_byte_num, tx_data, pkt_cnt, drop_cnt
  );
endinterface

// File: rtl/udp_loopback_buf.sv
// udp_loopback_buf: packet store-and-forward buffer from UDP rx payload stream to UDP tx replay
// Ports: clk, rst (sync, active-high); bus (udp_loopback_buf_if.slave) carries rec_en/rec_data/
// rec_pkt_done/rec_byte_num in, tx_start_en/tx_byte_num/tx_data out against tx_req/tx_done in,
// and pkt_cnt/drop_cnt out. Define UDP_LB_STATS_EN to build the commit/drop counters, else both read 0.
module udp_loopback_buf #(
  parameter int ADDR_W = 11,
  parameter int DESC_W = 2,
  parameter int TX_GAP = 16
) (
  input logic clk,
  input logic rst,
  udp_loopback_buf_if.slave bus
);
  localparam int P = ADDR_W + 1;
  localparam int D = DESC_W + 1;
  typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;
  state_t state, state_n;
  logic [7:0] ram [2**ADDR_W];
  logic [P-1:0] desc_start [2**DESC_W];
  logic [15:0] desc_len [2**DESC_W];
  logic [P-1:0] wr_tmp, wr_ptr, rd_base, rd_ptr, rd_end;
  logic [15:0] wcount, wcount_n, gap, byte_num;
  logic [DESC_W-1:0] wr_idx, rd_idx;
  logic [D-1:0] desc_cnt;
  logic [7:0] data;
  logic drop_mark, drop_n, ram_full, accept, commit, drop, pop, load;
  // full when the pointers differ only in the wrap bit: one whole RAM of uncommitted/unreleased bytes
  assign ram_full = wr_tmp == {~rd_base[ADDR_W], rd_base[ADDR_W-1:0]};
  assign accept = bus.rec_en && !drop_mark && !ram_full && !desc_cnt[DESC_W];
  assign drop_n = drop_mark || (bus.rec_en && !accept);
  assign wcount_n = wcount + {15'd0, accept};
  assign commit = bus.rec_pkt_done && !drop_n && wcount_n != 16'd0 && wcount_n == bus.rec_byte_num;
  assign drop = bus.rec_pkt_done && !commit;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? ((desc_cnt != '0 && gap == 16'd0) ? START : IDLE) :
              state == START ? SEND :
              state == SEND ? (bus.tx_done ? GAP : SEND) :
              (gap == 16'd0 ? IDLE : GAP);
  end
  assign pop = state == SEND && bus.tx_done;
  assign load = state == IDLE && state_n == START;
  assign bus.tx_start_en = state == START;
  assign bus.tx_byte_num = byte_num;
  assign bus.tx_data = data;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (accept) ram[wr_tmp[ADDR_W-1:0]] <= bus.rec_data;
    if (commit) begin
      desc_start[wr_idx] <= wr_ptr;
      desc_len[wr_idx] <= wcount_n;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_tmp <= '0;
      wr_ptr <= '0;
      rd_base <= '0;
      rd_ptr <= '0;
      rd_end <= '0;
      wcount <= '0;
      drop_mark <= 1'b0;
      wr_idx <= '0;
      rd_idx <= '0;
      desc_cnt <= '0;
      gap <= '0;
      byte_num <= '0;
      data <= '0;
    end else begin
      wr_tmp <= drop ? wr_ptr : wr_tmp + P'(accept);
      if (commit) wr_ptr <= wr_tmp + P'(accept);
      wcount <= bus.rec_pkt_done ? 16'd0 : wcount_n;
      drop_mark <= bus.rec_pkt_done ? 1'b0 : drop_n;
      wr_idx <= wr_idx + DESC_W'(commit);
      rd_idx <= rd_idx + DESC_W'(pop);
      desc_cnt <= desc_cnt + D'(commit) - D'(pop);
      // head descriptor is latched on entry to START so tx_byte_num is valid with tx_start_en
      if (load) begin
        rd_ptr <= desc_start[rd_idx];
        rd_end <= desc_start[rd_idx] + desc_len[rd_idx][P-1:0];
        byte_num <= desc_len[rd_idx];
      end
      // requests past the packet end leave rd_ptr and the last byte in place
      if (state == SEND && bus.tx_req && rd_ptr != rd_end) begin
        data <= ram[rd_ptr[ADDR_W-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
      // release the whole packet even if the transmitter read fewer bytes
      if (pop) rd_base <= rd_end;
      gap <= pop ? 16'(TX_GAP) : (state == GAP && gap != 16'd0) ? gap - 16'd1 : gap;
    end
  end
`ifdef UDP_LB_STATS_EN
  logic [15:0] pkt_q, drop_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_q <= '0;
      drop_q <= '0;
    end else begin
      if (commit && pkt_q != 16'hFFFF) pkt_q <= pkt_q + 16'd1;
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end
  assign bus.pkt_cnt = pkt_q;
  assign bus.drop_cnt = drop_q;
`else
  assign bus.pkt_cnt = '0;
  assign bus.drop_cnt = '0;
`endif
endmodule

// File: tb/tb_udp_loopback_buf.sv
// tb_udp_loopback_buf: scoreboard bench for udp_loopback_buf with a small RAM and short gap
module tb_udp_loopback_buf;
  localparam int ADDR_W = 6;
  localparam int DESC_W = 2;
  localparam int TX_GAP = 4;
`ifdef UDP_LB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  udp_loopback_buf_if bus();
  udp_loopback_buf #(.ADDR_W(ADDR_W), .DESC_W(DESC_W), .TX_GAP(TX_GAP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_byte[$];
  int exp_len[$];
  int com_cnt = 0, done_cnt = 0, start_cnt = 0, cyc = 0, last_done = -1, coinc = 0, token = 0;
  int tx_n = 0, tx_seen = 0;
  bit hold = 0, sync = 0, tx_waiting = 0, req_d = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int st(input int n);
    return STATS ? n : 0;
  endfunction
  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_tx_start_en"}, int'(bus.tx_start_en), 0);
    chk({tag, "_tx_byte_num"}, int'(bus.tx_byte_num), 0);
    chk({tag, "_tx_data"}, int'(bus.tx_data), 0);
    chk({tag, "_pkt_cnt"}, int'(bus.pkt_cnt), 0);
    chk({tag, "_drop_cnt"}, int'(bus.drop_cnt), 0);
  endtask
  // posedge bookkeeping: cycle count, request pipeline, tx_done time, rx/tx coincidences
  always @(posedge clk) begin
    cyc = cyc + 1;
    req_d = bus.tx_req;
    if (bus.tx_done) last_done = cyc;
    if (bus.tx_done && bus.rec_pkt_done) coinc = coinc + 1;
  end
  // monitor: pops expected lengths on tx_start_en and expected bytes one cycle after tx_req
  always @(negedge clk) begin
    if (bus.tx_start_en) begin
      start_cnt = start_cnt + 1;
      if (exp_len.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL start_unexpected: got tx_start_en with tx_byte_num=%0d expected none", bus.tx_byte_num);
      end else chk("tx_byte_num", int'(bus.tx_byte_num), exp_len.pop_front());
      if (last_done >= 0) begin
        checks++;
        if (cyc - last_done + 1 < TX_GAP + 2) begin
          failures++;
          $display("FAIL tx_gap: got %0d cycles expected >= %0d", cyc - last_done + 1, TX_GAP + 2);
        end
      end
    end
    if (req_d) begin
      if (exp_byte.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL data_unexpected: got tx_data=%0d expected none", bus.tx_data);
      end else chk("tx_data", int'(bus.tx_data), int'(exp_byte.pop_front()));
    end
  end
  // transmitter model: reads tx_byte_num bytes, then pulses tx_done (held off by hold, or aligned to a token)
  initial begin
    bus.tx_req = 1'b0;
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (bus.tx_start_en && !rst) begin
        tx_n = int'(bus.tx_byte_num);
        for (int i = 0; i < tx_n; i++) begin
          @(negedge clk);
          bus.tx_req = 1'b1;
        end
        @(negedge clk);
        bus.tx_req = 1'b0;
        tx_waiting = 1'b1;
        for (int t = 0; t < 5000; t++) begin
          if (!hold && (!sync || token != tx_seen || t >= 100)) break;
          @(negedge clk);
        end
        tx_seen = token;
        tx_waiting = 1'b0;
        bus.tx_done = 1'b1;
        done_cnt = done_cnt + 1;
      end
    end
  end
  task automatic send_pkt(input int n, input int num, input int seed, input bit with_last, input bit commit);
    for (int i = 0; i < n; i++) begin
      if (sync && with_last && i == n - 1) begin
        @(negedge clk);
        bus.rec_en = 1'b0;
        for (int t = 0; t < 400 && !(tx_waiting || com_cnt == done_cnt); t++) @(posedge clk);
        if (tx_waiting) begin
          @(posedge clk);
          token = token + 1;
        end
      end
      @(negedge clk);
      bus.rec_en = 1'b1;
      bus.rec_data = 8'(seed + i);
      if (commit) exp_byte.push_back(8'(seed + i));
      if (with_last && i == n - 1) begin
        bus.rec_pkt_done = 1'b1;
        bus.rec_byte_num = 16'(num);
      end
    end
    if (!with_last) begin
      @(negedge clk);
      bus.rec_en = 1'b0;
      bus.rec_pkt_done = 1'b1;
      bus.rec_byte_num = 16'(num);
    end
    if (commit) begin
      exp_len.push_back(num);
      com_cnt++;
    end
    @(negedge clk);
    bus.rec_en = 1'b0;
    bus.rec_pkt_done = 1'b0;
  endtask
  task automatic wait_done(input int target);
    for (int t = 0; t < 3000 && done_cnt < target; t++) @(negedge clk);
    chk("done_count", done_cnt, target);
  endtask
  int s0, c0;
  initial begin
    bus.rec_en = 1'b0;
    bus.rec_data = 8'd0;
    bus.rec_pkt_done = 1'b0;
    bus.rec_byte_num = 16'd0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;
    send_pkt(18, 18, 0, 1'b0, 1'b1);
    chk("latency_n1_start", int'(bus.tx_start_en), 0);
    @(negedge clk);
    chk("latency_n2_start", int'(bus.tx_start_en), 1);
    wait_done(1);
    chk("single_pkt_cnt", int'(bus.pkt_cnt), st(1));
    chk("single_drop_cnt", int'(bus.drop_cnt), st(0));
    send_pkt(10, 12, 8'h40, 1'b0, 1'b0);
    send_pkt(4, 4, 8'hA0, 1'b0, 1'b1);
    wait_done(2);
    chk("mismatch_drop_cnt", int'(bus.drop_cnt), st(1));
    chk("mismatch_pkt_cnt", int'(bus.pkt_cnt), st(2));
    send_pkt(70, 70, 8'h10, 1'b0, 1'b0);
    send_pkt(64, 64, 8'h80, 1'b0, 1'b1);
    wait_done(3);
    chk("overflow_drop_cnt", int'(bus.drop_cnt), st(2));
    chk("overflow_pkt_cnt", int'(bus.pkt_cnt), st(3));
    hold = 1'b1;
    s0 = start_cnt;
    for (int k = 0; k < 5; k++) send_pkt(8, 8, k * 16, 1'b0, k < 4);
    chk("descfull_drop_cnt", int'(bus.drop_cnt), st(3));
    chk("descfull_starts_held", start_cnt - s0, 1);
    hold = 1'b0;
    wait_done(7);
    repeat (12) @(negedge clk);
    chk("descfull_starts", start_cnt - s0, 4);
    chk("descfull_pkt_cnt", int'(bus.pkt_cnt), st(7));
    sync = 1'b1;
    c0 = coinc;
    for (int j = 0; j < 20; j++) begin
      for (int t = 0; t < 2000 && com_cnt - done_cnt > 1; t++) @(negedge clk);
      send_pkt(24, 24, j * 7, 1'b1, 1'b1);
    end
    wait_done(27);
    sync = 1'b0;
    chk("wrap_coincident_done", coinc - c0, 19);
    chk("wrap_pkt_cnt", int'(bus.pkt_cnt), st(27));
    chk("wrap_drop_cnt", int'(bus.drop_cnt), st(3));
    hold = 1'b1;
    send_pkt(16, 16, 8'h55, 1'b0, 1'b1);
    for (int t = 0; t < 200 && !tx_waiting; t++) @(negedge clk);
    chk("midsend_waiting", int'(tx_waiting), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.rec_en = 1'b1;
      bus.rec_data = 8'(8'hE0 + i);
    end
    @(negedge clk);
    bus.rec_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_zero_outputs("midsend_rst");
    rst = 1'b0;
    s0 = start_cnt;
    hold = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_rst_starts", start_cnt - s0, 0);
    send_pkt(3, 3, 8'hC0, 1'b0, 1'b1);
    wait_done(29);
    chk("post_rst_pkt_cnt", int'(bus.pkt_cnt), st(1));
    chk("post_rst_drop_cnt", int'(bus.drop_cnt), st(0));
    repeat (4) @(negedge clk);
    chk("exp_len_left", exp_len.size(), 0);
    chk("exp_byte_left", exp_byte.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
